decode_stage: RTL and testbench
===============================

# decode_stage

Registered, handshaked successor to the combinational instruction decoder in the nandgame core. It is parametrised in data width and decodes one 16-bit instruction per accepted transfer:
- A-instructions produce an immediate.
- C-instructions compute the ALU result, destination mask and jump decision from operands sampled at acceptance.

Results pass through a 2-entry output buffer with valid/ready backpressure, a synchronous flush, and saturating retire counters. It sits between fetch and writeback/PC update.

## Interface
- W, 16: data width of operands and result; W >= 16.
- CNT_W, 16: width of each retire counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instruction  in  16  instruction word; qualified by in_valid.
- a_reg  in  W  A register value, sampled at acceptance.
- d_reg  in  W  D register value, sampled at acceptance.
- a_mem_reg  in  W  *A (memory at A) value, sampled at acceptance.
- in_valid  in  1  instruction and operands are valid.
- in_ready  out  1  buffer can accept; high when occupancy < 2.
- flush  in  1  discards all buffered entries and any same-cycle input.
- out  out  W  result of the head entry.
- dst  out  3  destination mask of the head entry: [2]=A, [1]=D, [0]=*A.
- jmp  out  1  jump-taken flag of the head entry.
- out_valid  out  1  head entry present; high when occupancy > 0.
- out_ready  in  1  consumer takes the head entry.
- instr_cnt  out  CNT_W  entries delivered (popped).
- jmp_cnt  out  CNT_W  delivered entries with jmp=1.

## Operation
**A-instruction (instruction[15]=0)**
- out = zero-extend(instruction[14:0]) to W.
- dst = 3'b100, jmp = 0.

**C-instruction (instruction[15]=1)**
- Operands:
  - X = d_reg.
  - Y = instruction[12] ? a_mem_reg : a_reg.
- Operand modifiers, applied in order:
  - sw (bit 6) swaps X and Y.
  - zx (bit 7) forces the post-swap X to 0.
- Function select by u (bit 10) and op (bits 9:8):
  - u=1: 00 X+Y, 01 X+1, 10 X−Y, 11 X−1. Arithmetic is modulo 2^W; carry is discarded.
  - u=0: 00 X&Y, 01 X|Y, 10 X^Y, 11 ~X.
- dst = instruction[5:3].
- Jump condition, with the result interpreted as signed W-bit:
  - jmp = (bit2 & result<0) | (bit1 & result==0) | (bit0 & result>0).
  - Bits 2:0 = 111 gives an unconditional jump.
- Bits 14:13 and 11 are ignored.

**Buffer**
- 2-entry FIFO. Each entry holds {out, dst, jmp}.
- Push when in_valid & in_ready & !flush. Decode is computed combinationally from the current inputs and written on that edge.
- Pop when out_valid & out_ready & !flush.
- Push and pop in the same cycle is allowed at occupancy 1. At occupancy 2, in_ready=0, so only a pop can occur.
- Outputs always show the head entry. When out_valid=0, out/dst/jmp hold their last value; consumers must ignore them.
- Flush has priority: occupancy becomes 0, and any same-cycle push and pop are suppressed. Counters do not increment for suppressed pops.

**Counters**
- On each non-suppressed pop: instr_cnt += 1; jmp_cnt += 1 if the popped jmp=1.
- Both saturate at 2^CNT_W−1.
- Cleared only by rst; flush does not clear them.

## Timing
- Reset values:
  - occupancy 0, so out_valid=0 and in_ready=1.
  - out=0, dst=0, jmp=0.
  - instr_cnt=0, jmp_cnt=0.
- rst overrides flush and all handshakes.
- Latency: an instruction accepted at edge N with the buffer empty drives out_valid=1 and its result in the cycle after edge N.
- Throughput: one per cycle while out_ready=1.
- in_ready depends only on occupancy, with no combinational path from out_ready. Consequences:
  - At occupancy 2, a pop does not reopen in_ready until the next cycle.
  - Sustained full throughput runs at occupancy 1.
- Operands are sampled only at the accepting edge; later changes do not affect buffered entries.
- Flush or rst at any occupancy: the next cycle shows out_valid=0, in_ready=1.

## Test plan
- **A-instruction:** after reset, push 0x1234 with out_ready=1 → next cycle out=0x1234, dst=100, jmp=0, out_valid=1; instr_cnt=1 after the pop.
- **C-instruction add:** 0x8410 with d_reg=3, a_reg=5 → out=8, dst=010, jmp=0. Repeat with bit12 set (0x9410) and a_mem_reg=10 → out=13.
- **Jumps:**
  - 0x8702 with d_reg=1 → out=0, jmp=1.
  - 0x8604 with d_reg=2, a_reg=5 → out=0xFFFD, jmp=1.
  - jmp_cnt=2 after both pops.
- **Backpressure:** out_ready=0, push 3 instructions back-to-back → third stalls (in_ready=0 after 2 accepts). Raise out_ready → outputs appear in order, with no loss or duplication.
- **Flush:** occupancy 2 plus in_valid=1 in the flush cycle → next cycle out_valid=0, in_ready=1; counters unchanged; the flushed-cycle input never appears.
- **Width and saturation:**
  - W=24: A-instruction 0x7FFF → out=0x007FFF; D−1 with d_reg=0 → out=0xFFFFFF and jlt taken.
  - CNT_W=2: 5 pops → instr_cnt stays at 3.

Source files
------------

// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, decode_stage and writeback/PC update.
// Carries the instruction with its operands in, and the decoded head entry out.
interface decode_stage_if #(
  parameter int W = 16
);
  logic [15:0]  instruction;
  logic [W-1:0] a_reg;
  logic [W-1:0] d_reg;
  logic [W-1:0] a_mem_reg;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out;
  logic [2:0]   dst;
  logic         jmp;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output instruction, a_reg, d_reg, a_mem_reg,
    output in_valid, out_ready,
    input  in_ready, out, dst, jmp, out_valid
  );

  modport slave (
    input  instruction, a_reg, d_reg, a_mem_reg,
    input  in_valid, out_ready,
    output in_ready, out, dst, jmp, out_valid
  );
endinterface

// File: rtl/decode_stage.sv
// Registered nandgame instruction decoder with a 2-entry output buffer,
// synchronous flush and saturating retire counters.
module decode_stage #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] jmp_cnt
);

  typedef struct packed {
    logic [W-1:0] res;
    logic [2:0]   dst;
    logic         jmp;
  } ent_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [15:0]  ins;
  logic [W-1:0] y0;
  logic [W-1:0] xs;
  logic [W-1:0] ys;
  logic [W-1:0] x;
  logic [W-1:0] res;
  logic         neg;
  logic         zero;
  logic         pos;
  ent_t         nxt;
  ent_t         e0;
  ent_t         e1;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign ins = bus.instruction;
  assign y0  = ins[12] ? bus.a_mem_reg : bus.a_reg;
  // swap first, then zero the post-swap X
  assign xs  = ins[6] ? y0 : bus.d_reg;
  assign ys  = ins[6] ? bus.d_reg : y0;
  assign x   = ins[7] ? '0 : xs;

  always_comb begin
    res = '0;
    unique case ({ins[10], ins[9:8]})
      3'b100: res = x + ys;
      3'b101: res = x + ONE;
      3'b110: res = x - ys;
      3'b111: res = x - ONE;
      3'b000: res = x & ys;
      3'b001: res = x | ys;
      3'b010: res = x ^ ys;
      3'b011: res = ~x;
      default: res = '0;
    endcase
  end

  assign neg  = res[W-1];
  assign zero = (res == '0);
  assign pos  = !neg && !zero;

  always_comb begin
    nxt = '0;
    unique case (1'b1)
      !ins[15]: begin
        nxt.res = {{(W-15){1'b0}}, ins[14:0]};
        nxt.dst = 3'b100;
      end
      ins[15]: begin
        nxt.res = res;
        nxt.dst = ins[5:3];
        nxt.jmp = (ins[2] & neg) | (ins[1] & zero) | (ins[0] & pos);
      end
      default: nxt = '0;
    endcase
  end

  assign bus.in_ready  = !cnt[1];
  assign bus.out_valid = (cnt != 2'd0);
  assign bus.out       = e0.res;
  assign bus.dst       = e0.dst;
  assign bus.jmp       = e0.jmp;

  assign push = bus.in_valid & bus.in_ready & !flush;
  assign pop  = bus.out_valid & bus.out_ready & !flush;

  // e0 is always the head; it keeps its value when the buffer drains
  always_ff @(posedge clk) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= nxt;
          else             e1 <= nxt;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd2) e0 <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: e0 <= nxt;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt <= '0;
      jmp_cnt   <= '0;
    end else if (pop) begin
      if (instr_cnt != '1) instr_cnt <= instr_cnt + 1'b1;
      if (e0.jmp && jmp_cnt != '1) jmp_cnt <= jmp_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: W=16/CNT_W=16 and W=24/CNT_W=2 instances.
// Stimulus pushes expected entries; per-instance monitors pop and compare.
module tb_decode_stage;

  typedef struct {
    logic [23:0] o;
    logic [2:0]  d;
    logic        j;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush16 = 1'b0;
  logic flush24 = 1'b0;
  logic [15:0] ic16, jc16;
  logic [1:0]  ic24, jc24;
  int n_run = 0;
  int n_fail = 0;
  exp_t q16[$];
  exp_t q24[$];

  decode_stage_if #(.W(16)) b16 ();
  decode_stage_if #(.W(24)) b24 ();

  decode_stage #(.W(16), .CNT_W(16)) u16 (
    .clk(clk), .rst(rst), .flush(flush16), .bus(b16.slave),
    .instr_cnt(ic16), .jmp_cnt(jc16)
  );

  decode_stage #(.W(24), .CNT_W(2)) u24 (
    .clk(clk), .rst(rst), .flush(flush24), .bus(b24.slave),
    .instr_cnt(ic24), .jmp_cnt(jc24)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush16 && b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL mon16 unexpected out=%h exp=none", b16.out);
      end else begin
        e = q16.pop_front();
        chk("mon16 out", 32'(b16.out), 32'(e.o));
        chk("mon16 dst", 32'(b16.dst), 32'(e.d));
        chk("mon16 jmp", 32'(b16.jmp), 32'(e.j));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush24 && b24.out_valid && b24.out_ready) begin
      if (q24.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL mon24 unexpected out=%h exp=none", b24.out);
      end else begin
        e = q24.pop_front();
        chk("mon24 out", 32'(b24.out), 32'(e.o));
        chk("mon24 dst", 32'(b24.dst), 32'(e.d));
        chk("mon24 jmp", 32'(b24.jmp), 32'(e.j));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push16(input logic [15:0] ins, input logic [15:0] d,
                        input logic [15:0] a, input logic [15:0] m,
                        input logic [15:0] eo, input logic [2:0] ed,
                        input logic ej);
    int n;
    n = 0;
    b16.instruction = ins;
    b16.d_reg = d;
    b16.a_reg = a;
    b16.a_mem_reg = m;
    b16.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (b16.in_ready) break;
      n++;
      if (n > 50) begin
        n_run++;
        n_fail++;
        $display("FAIL push16 timeout ins=%h got=stall exp=accept", ins);
        break;
      end
    end
    if (n <= 50) q16.push_back('{24'(eo), ed, ej});
    @(posedge clk);
    #1;
    b16.in_valid = 1'b0;
  endtask

  task automatic push24(input logic [15:0] ins, input logic [23:0] d,
                        input logic [23:0] a, input logic [23:0] m,
                        input logic [23:0] eo, input logic [2:0] ed,
                        input logic ej);
    int n;
    n = 0;
    b24.instruction = ins;
    b24.d_reg = d;
    b24.a_reg = a;
    b24.a_mem_reg = m;
    b24.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (b24.in_ready) break;
      n++;
      if (n > 50) begin
        n_run++;
        n_fail++;
        $display("FAIL push24 timeout ins=%h got=stall exp=accept", ins);
        break;
      end
    end
    if (n <= 50) q24.push_back('{eo, ed, ej});
    @(posedge clk);
    #1;
    b24.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    b16.instruction = '0; b16.d_reg = '0; b16.a_reg = '0;
    b16.a_mem_reg = '0; b16.in_valid = 1'b0; b16.out_ready = 1'b1;
    b24.instruction = '0; b24.d_reg = '0; b24.a_reg = '0;
    b24.a_mem_reg = '0; b24.in_valid = 1'b0; b24.out_ready = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk("rst out_valid", 32'(b16.out_valid), 0);
    chk("rst in_ready", 32'(b16.in_ready), 1);
    chk("rst out", 32'(b16.out), 0);
    chk("rst dst", 32'(b16.dst), 0);
    chk("rst jmp", 32'(b16.jmp), 0);
    chk("rst instr_cnt", 32'(ic16), 0);
    chk("rst jmp_cnt", 32'(jc16), 0);
    chk("rst24 out_valid", 32'(b24.out_valid), 0);

    push16(16'h1234, 16'h0, 16'h0, 16'h0, 16'h1234, 3'b100, 1'b0);
    chk("a latency valid", 32'(b16.out_valid), 1);
    chk("a latency out", 32'(b16.out), 32'h1234);
    cyc(1);
    chk("a instr_cnt", 32'(ic16), 1);

    push16(16'h8410, 16'd3, 16'd5, 16'd10, 16'd8, 3'b010, 1'b0);
    push16(16'h9410, 16'd3, 16'd5, 16'd10, 16'd13, 3'b010, 1'b0);
    push16(16'h8702, 16'd1, 16'd0, 16'd0, 16'h0000, 3'b000, 1'b1);
    push16(16'h8604, 16'd2, 16'd5, 16'd0, 16'hFFFD, 3'b000, 1'b1);
    cyc(2);
    chk("jump instr_cnt", 32'(ic16), 5);
    chk("jump jmp_cnt", 32'(jc16), 2);

    push16(16'h8000, 16'h0F0F, 16'h00FF, 16'h0, 16'h000F, 3'b000, 1'b0);
    push16(16'h8640, 16'd2, 16'd5, 16'h0, 16'h0003, 3'b000, 1'b0);
    push16(16'h8680, 16'd2, 16'd5, 16'h0, 16'hFFFB, 3'b000, 1'b0);
    push16(16'h8328, 16'h00FF, 16'h0, 16'h0, 16'hFF00, 3'b101, 1'b0);
    push16(16'h8401, 16'd1, 16'd1, 16'h0, 16'h0002, 3'b000, 1'b1);
    push16(16'h8201, 16'd5, 16'd5, 16'h0, 16'h0000, 3'b000, 1'b0);
    cyc(2);
    chk("logic instr_cnt", 32'(ic16), 11);
    chk("logic jmp_cnt", 32'(jc16), 3);

    b16.out_ready = 1'b0;
    push16(16'h0011, 16'h0, 16'h0, 16'h0, 16'h0011, 3'b100, 1'b0);
    push16(16'h0022, 16'h0, 16'h0, 16'h0, 16'h0022, 3'b100, 1'b0);
    chk("bp in_ready", 32'(b16.in_ready), 0);
    chk("bp head", 32'(b16.out), 32'h0011);
    b16.instruction = 16'h0033;
    b16.in_valid = 1'b1;
    cyc(2);
    chk("bp stall in_ready", 32'(b16.in_ready), 0);
    chk("bp stall cnt", 32'(ic16), 11);
    b16.out_ready = 1'b1;
    push16(16'h0033, 16'h0, 16'h0, 16'h0, 16'h0033, 3'b100, 1'b0);
    cyc(3);
    chk("bp instr_cnt", 32'(ic16), 14);

    b16.out_ready = 1'b0;
    push16(16'h0101, 16'h0, 16'h0, 16'h0, 16'h0101, 3'b100, 1'b0);
    push16(16'h0202, 16'h0, 16'h0, 16'h0, 16'h0202, 3'b100, 1'b0);
    b16.instruction = 16'h0303;
    b16.in_valid = 1'b1;
    b16.out_ready = 1'b1;
    flush16 = 1'b1;
    @(posedge clk);
    #1;
    flush16 = 1'b0;
    b16.in_valid = 1'b0;
    q16.delete();
    chk("flush out_valid", 32'(b16.out_valid), 0);
    chk("flush in_ready", 32'(b16.in_ready), 1);
    chk("flush instr_cnt", 32'(ic16), 14);
    chk("flush jmp_cnt", 32'(jc16), 3);
    cyc(3);
    chk("flush stays empty", 32'(b16.out_valid), 0);
    push16(16'h0404, 16'h0, 16'h0, 16'h0, 16'h0404, 3'b100, 1'b0);
    cyc(2);
    chk("post flush cnt", 32'(ic16), 15);

    push24(16'h7FFF, 24'h0, 24'h0, 24'h0, 24'h007FFF, 3'b100, 1'b0);
    push24(16'h8704, 24'h0, 24'h0, 24'h0, 24'hFFFFFF, 3'b000, 1'b1);
    push24(16'h8410, 24'hFFFFFF, 24'd2, 24'h0, 24'h000001, 3'b010, 1'b0);
    push24(16'h0001, 24'h0, 24'h0, 24'h0, 24'h000001, 3'b100, 1'b0);
    push24(16'h0002, 24'h0, 24'h0, 24'h0, 24'h000002, 3'b100, 1'b0);
    cyc(2);
    chk("w24 instr_cnt sat", 32'(ic24), 3);
    chk("w24 jmp_cnt", 32'(jc24), 1);

    chk("q16 drained", 32'(q16.size()), 0);
    chk("q24 drained", 32'(q24.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
